// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data request ports and the shared memory port of mem_arbiter.
// master is the arbiter's view; slave is the view of the requesters plus the memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W/8-1:0] d_wstrb;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              err;
    logic              m_valid;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, err, m_valid, m_we, m_addr, m_wdata, m_wstrb
    );
    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, err, m_valid, m_we, m_addr, m_wdata, m_wstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and load/store accesses onto one memory port,
// data-first with a bounded fetch starvation streak and an optional memory timeout.
module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 16
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_t;
    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] timer;
    logic          grant_d;
    logic          grant_i;
    logic          expired;
    assign grant_d = bus.d_req && (!bus.i_req || streak < STREAK_MAX);
    assign grant_i = !grant_d && bus.i_req;
    assign expired = TIMEOUT != 0 && timer == TIMER_LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= '0;
            timer       <= '0;
            bus.m_valid <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.m_wstrb <= '0;
            bus.i_ack   <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.err     <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
        end else begin
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;
            bus.err   <= 1'b0;
            case (state)
                IDLE: if (grant_d || grant_i) begin
                    state       <= grant_d ? BUSY_D : BUSY_I;
                    timer       <= '0;
                    bus.m_valid <= 1'b1;
                    bus.m_we    <= grant_d && bus.d_we;
                    bus.m_addr  <= grant_d ? bus.d_addr : bus.i_addr;
                    bus.m_wdata <= grant_d ? bus.d_wdata : '0;
                    bus.m_wstrb <= grant_d ? bus.d_wstrb : '0;
                    // a data grant with fetch waiting implies streak < max, so this saturates
                    streak      <= (grant_d && bus.i_req) ? streak + 1'b1 : '0;
                end
                BUSY_D, BUSY_I: if (bus.m_ready || expired) begin
                    state       <= RESP;
                    bus.m_valid <= 1'b0;
                    bus.err     <= !bus.m_ready;
                    if (state == BUSY_D) begin
                        bus.d_ack   <= 1'b1;
                        bus.d_rdata <= bus.m_ready ? bus.m_rdata : '0;
                    end else begin
                        bus.i_ack   <= 1'b1;
                        bus.i_rdata <= bus.m_ready ? bus.m_rdata : '0;
                    end
                end else begin
                    timer <= timer + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a transaction-level
// model of the arbitration, latency and timeout rules.
module tb_mem_arbiter;
    localparam int AW = 32, DW = 32, MAXS = 4, TO = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    int n_tests = 0;
    int n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        bus.m_ready = 0; bus.m_rdata = '0;
    endtask

    task automatic serve(input logic [DW-1:0] rd);
        bus.m_ready = 1; bus.m_rdata = rd;
        step();
        bus.m_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step(); step();
        n_tests++;
        if ({bus.i_ack, bus.d_ack, bus.err, bus.m_valid, bus.m_we, bus.m_addr, bus.m_wdata,
             bus.m_wstrb, bus.i_rdata, bus.d_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
        end
        rst = 0;
        step(); step();
        n_tests++;
        if (bus.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_req: m_valid=%b required 0", bus.m_valid);
        end
    endtask

    task automatic test_fetch();
        bus.i_req = 1; bus.i_addr = 32'h40;
        step();
        n_tests++;
        if ({bus.m_valid, bus.m_we, bus.m_addr, bus.m_wstrb} !== {1'b1, 1'b0, 32'h40, 4'h0}) begin
            n_fail++; $display("FAIL fetch_issue: valid=%b we=%b addr=%h strb=%h required 1 0 40 0",
                               bus.m_valid, bus.m_we, bus.m_addr, bus.m_wstrb);
        end
        serve(32'h00500093);
        n_tests++;
        if ({bus.i_ack, bus.d_ack, bus.err, bus.m_valid, bus.i_rdata} !== {4'b1000, 32'h00500093}) begin
            n_fail++; $display("FAIL fetch_ack: iack=%b dack=%b err=%b valid=%b rdata=%h required 1 0 0 0 00500093",
                               bus.i_ack, bus.d_ack, bus.err, bus.m_valid, bus.i_rdata);
        end
        bus.i_req = 0;
        step();
        n_tests++;
        if ({bus.i_ack, bus.i_rdata} !== {1'b0, 32'h00500093}) begin
            n_fail++; $display("FAIL fetch_pulse_hold: iack=%b rdata=%h required 0 00500093", bus.i_ack, bus.i_rdata);
        end
    endtask

    task automatic test_simultaneous();
        bus.i_req = 1; bus.i_addr = 32'h44;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'hF;
        step();
        n_tests++;
        if ({bus.m_valid, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb} !== {2'b11, 32'h100, 32'hDEADBEEF, 4'hF}) begin
            n_fail++; $display("FAIL simul_store_issue: we=%b addr=%h wdata=%h strb=%h required 1 100 deadbeef f",
                               bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb);
        end
        serve(32'h0);
        n_tests++;
        if ({bus.d_ack, bus.i_ack, bus.err} !== 3'b100) begin
            n_fail++; $display("FAIL simul_store_ack: dack=%b iack=%b err=%b required 1 0 0", bus.d_ack, bus.i_ack, bus.err);
        end
        step();
        bus.d_req = 0;
        step();
        n_tests++;
        if ({bus.m_valid, bus.m_we, bus.m_addr, bus.m_wstrb} !== {2'b10, 32'h44, 4'h0}) begin
            n_fail++; $display("FAIL simul_fetch_next: valid=%b we=%b addr=%h strb=%h required 1 0 44 0",
                               bus.m_valid, bus.m_we, bus.m_addr, bus.m_wstrb);
        end
        serve(32'h13);
        n_tests++;
        if ({bus.i_ack, bus.i_rdata} !== {1'b1, 32'h13}) begin
            n_fail++; $display("FAIL simul_fetch_ack: iack=%b rdata=%h required 1 13", bus.i_ack, bus.i_rdata);
        end
        bus.i_req = 0;
        step();
    endtask

    task automatic both_req_order(input string name, input int n, input int i1, input int i2);
        bit got_i, exp_i;
        bus.i_req = 1; bus.i_addr = 32'h80;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        for (int g = 0; g < n; g++) begin
            step();
            got_i = bus.m_valid && bus.m_addr == 32'h80;
            serve($urandom);
            exp_i = (g == i1 || g == i2);
            n_tests++;
            if ({got_i, bus.i_ack, bus.d_ack} !== {exp_i, exp_i, !exp_i}) begin
                n_fail++; $display("FAIL %s grant %0d: fetch_granted=%b iack=%b dack=%b required fetch=%b",
                                   name, g, got_i, bus.i_ack, bus.d_ack, exp_i);
            end
            step();
            if (!exp_i) bus.d_addr = bus.d_addr + 4;
        end
        bus.i_req = 0; bus.d_req = 0;
    endtask

    task automatic test_starvation();
        both_req_order("starvation", 10, 4, 9);
    endtask

    task automatic test_wait_states();
        bit stable = 1;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        step();
        for (int c = 0; c < 5; c++) begin
            if (!(bus.m_valid && bus.m_addr == 32'h300 && !bus.d_ack)) stable = 0;
            step();
        end
        if (!(bus.m_valid && bus.m_addr == 32'h300)) stable = 0;
        n_tests++;
        if (stable !== 1'b1) begin
            n_fail++; $display("FAIL wait_stable: m_valid/m_addr stable=%b required 1", stable);
        end
        serve(32'hCAFE0001);
        n_tests++;
        if ({bus.d_ack, bus.err, bus.m_valid, bus.d_rdata} !== {3'b100, 32'hCAFE0001}) begin
            n_fail++; $display("FAIL wait_ack: dack=%b err=%b valid=%b rdata=%h required 1 0 0 cafe0001",
                               bus.d_ack, bus.err, bus.m_valid, bus.d_rdata);
        end
        bus.d_req = 0;
        step();
        n_tests++;
        if (bus.d_ack !== 1'b0) begin
            n_fail++; $display("FAIL wait_single_ack: dack=%b required 0", bus.d_ack);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
        step();
        while (bus.m_valid === 1'b1 && n < 40) begin
            n++;
            step();
        end
        n_tests++;
        if (n != TO) begin
            n_fail++; $display("FAIL timeout_len: m_valid high %0d cycles required %0d", n, TO);
        end
        n_tests++;
        if ({bus.d_ack, bus.err, bus.i_ack, bus.d_rdata} !== {3'b110, 32'h0}) begin
            n_fail++; $display("FAIL timeout_resp: dack=%b err=%b iack=%b rdata=%h required 1 1 0 0",
                               bus.d_ack, bus.err, bus.i_ack, bus.d_rdata);
        end
        bus.d_req = 0;
        step();
        bus.m_ready = 1; bus.m_rdata = 32'h55;
        step();
        bus.m_ready = 0;
        n_tests++;
        if ({bus.i_ack, bus.d_ack, bus.err, bus.m_valid} !== 4'b0) begin
            n_fail++; $display("FAIL ready_in_idle: iack=%b dack=%b err=%b valid=%b required 0 0 0 0",
                               bus.i_ack, bus.d_ack, bus.err, bus.m_valid);
        end
        bus.i_req = 1; bus.i_addr = 32'h48;
        step();
        serve(32'h77);
        n_tests++;
        if ({bus.i_ack, bus.err, bus.i_rdata} !== {2'b10, 32'h77}) begin
            n_fail++; $display("FAIL after_timeout: iack=%b err=%b rdata=%h required 1 0 77", bus.i_ack, bus.err, bus.i_rdata);
        end
        bus.i_req = 0;
        step();
    endtask

    task automatic test_reset_mid_busy();
        bus.i_req = 1; bus.i_addr = 32'h80;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
        for (int g = 0; g < 3; g++) begin
            step();
            serve($urandom | 1);
            step();
        end
        step();
        step(); step();
        rst = 1;
        #1;
        n_tests++;
        if ({bus.m_valid, bus.i_ack, bus.d_ack, bus.err, bus.d_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_mid_busy: valid=%b iack=%b dack=%b err=%b drdata=%h required all 0",
                               bus.m_valid, bus.i_ack, bus.d_ack, bus.err, bus.d_rdata);
        end
        idle_inputs();
        step();
        rst = 0;
        step();
        both_req_order("post_reset", 5, 4, 4);
    endtask

    task automatic test_random();
        bit ip = 0, dp = 0, gd, to_x;
        logic [AW-1:0] ia = '0, da = '0;
        logic [DW-1:0] dwd = '0, rd, exp_rd, got_rd;
        logic [DW/8-1:0] dws = '0;
        logic dwe = 0;
        int waited = 0, d;
        for (int t = 0; t < 200; t++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin ip = 1; ia = $urandom & ~32'h3; end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; da = $urandom | 32'h1; dwe = 1'($urandom); dwd = $urandom; dws = 4'($urandom);
            end
            if (!ip && !dp) begin ip = 1; ia = $urandom & ~32'h3; end
            bus.i_req = ip; bus.i_addr = ia;
            bus.d_req = dp; bus.d_addr = da; bus.d_we = dwe; bus.d_wdata = dwd; bus.d_wstrb = dws;
            // fetch may be overtaken by at most MAXS data grants in a row
            gd = dp && (!ip || waited < MAXS);
            waited = (gd && ip) ? waited + 1 : 0;
            step();
            n_tests++;
            if ({bus.m_valid, bus.m_we, bus.m_addr, bus.m_wstrb} !==
                {1'b1, gd && dwe, gd ? da : ia, gd ? dws : 4'h0}) begin
                n_fail++; $display("FAIL rand_issue %0d: we=%b addr=%h strb=%h required we=%b addr=%h strb=%h",
                                   t, bus.m_we, bus.m_addr, bus.m_wstrb, gd && dwe, gd ? da : ia, gd ? dws : 4'h0);
            end
            if (gd && dwe) begin
                n_tests++;
                if (bus.m_wdata !== dwd) begin
                    n_fail++; $display("FAIL rand_wdata %0d: %h required %h", t, bus.m_wdata, dwd);
                end
            end
            to_x = $urandom_range(0, 9) == 0;
            d = to_x ? TO : $urandom_range(0, 4);
            for (int c = 0; c < d; c++) step();
            rd = $urandom;
            if (!to_x) serve(rd);
            exp_rd = to_x ? '0 : rd;
            got_rd = gd ? bus.d_rdata : bus.i_rdata;
            n_tests++;
            if ({bus.i_ack, bus.d_ack, bus.err, got_rd} !== {!gd, gd, to_x, exp_rd}) begin
                n_fail++; $display("FAIL rand_resp %0d: iack=%b dack=%b err=%b rdata=%h required %b %b %b %h",
                                   t, bus.i_ack, bus.d_ack, bus.err, got_rd, !gd, gd, to_x, exp_rd);
            end
            step();
            if (gd) dp = 0; else ip = 0;
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_wait_states();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
